// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory write port: length header, big-endian words, cpu_hold while busy.
// Optional checksum trailer byte enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned       CNT_W   = 11;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_CNT = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL_STATE = S_CHK;
`else
    localparam state_t TAIL_STATE = S_DONE;
`endif

    state_t            state;
    state_t            state_next;
    logic [2:0]        len_hi;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  index;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift_q;
    logic              xfer;
    logic [CNT_W-1:0]  count_new;
    logic              oversize;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign count_new = {len_hi, in_data};
    assign oversize  = 32'(count_new) > MAX_CNT;
    assign last_word = (index + CNT_W'(1)) == count;
    assign xfer      = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        cpu_hold   = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (count_new == '0)  state_next = TAIL_STATE;
                    else if (oversize)    state_next = S_DONE;
                    else                  state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_en      = 1'b1;
                state_next = last_word ? TAIL_STATE : S_DATA;
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // wr_addr/wr_data are captured with the 4th byte so they are stable throughout WRITE
    // and keep their values while the next word assembles in shift_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi   <= '0;
            count    <= '0;
            index    <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        index    <= '0;
                        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (xfer) len_hi <= in_data[2:0];
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        count <= count_new;
                        if (oversize) err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        shift_q  <= {shift_q[15:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            wr_data <= {shift_q, in_data};
                            wr_addr <= BASE + ADDR_W'(index);
                        end
                    end
                end
                S_WRITE: begin
                    index <= index + CNT_W'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer && in_data != csum) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table vectors, randomized loads against a stream-level model,
// and hand-written reset-abort sequence. Honours LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

    localparam int          ADDR_W = 10;
    localparam int unsigned BASE   = 0;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        int unsigned nw;
        logic [31:0] w [4];
        bit          bad;
        logic        exp_err;
        int unsigned exp_nwr;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            chk("in_ready_in_write", 32'(in_ready), 32'd0);
        end
        if (done) done_cnt++;
    end

    // Reference model: parse the byte stream directly into expected (addr, word) writes and err.
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              model_err;

    function automatic void model(input byte_q_t s);
        int unsigned cnt;
        logic [7:0]  x;
        exp_addr.delete();
        exp_data.delete();
        model_err = 1'b0;
        x = 8'h00;
        cnt = 32'({s[0][2:0], s[1]});
        if (cnt > (32'd1 << ADDR_W)) begin
            model_err = 1'b1;
            return;
        end
        for (int unsigned i = 0; i < cnt; i++) begin
            exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
            exp_addr.push_back(ADDR_W'((BASE + i) % (32'd1 << ADDR_W)));
            for (int unsigned k = 0; k < 4; k++) x = x ^ s[2+4*i+k];
        end
        if (CHK_EN) model_err = (s[2+4*cnt] != x);
    endfunction

    function automatic byte_q_t build_stream(input logic [7:0] hi, input logic [7:0] lo,
                                             input word_q_t words, input bit bad);
        byte_q_t     s;
        logic [7:0]  x;
        int unsigned cnt;
        x = 8'h00;
        s.push_back(hi);
        s.push_back(lo);
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                s.push_back(words[i][8*k +: 8]);
                x = x ^ words[i][8*k +: 8];
            end
        end
        cnt = 32'({hi[2:0], lo});
        if (CHK_EN && cnt <= (32'd1 << ADDR_W)) s.push_back(x ^ {7'd0, bad});
        return s;
    endfunction

    task automatic run_load(input byte_q_t s, input bit rnd, input bit spam,
                            input logic exp_err, input int exp_nwr, input string tag);
        int idx;
        int cyc;
        logic rdy;
        model(s);
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s_err_cleared", tag), 32'(err), 32'd0);
        chk($sformatf("%s_hold_after_start", tag), 32'(cpu_hold), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < s.size() && cyc < 50 * s.size() + 100) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? s[idx] : 8'($urandom);
            if (spam) start = ($urandom_range(0, 3) == 0);
            rdy = in_ready;
            chk($sformatf("%s_hold_busy", tag), 32'(cpu_hold), 32'd1);
            @(posedge clk);
            if (in_valid && rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk($sformatf("%s_all_bytes_taken", tag), 32'(idx), 32'(s.size()));
        cyc = 0;
        while (!done && cyc < 20) begin
            chk($sformatf("%s_hold_wait", tag), 32'(cpu_hold), 32'd1);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
        chk($sformatf("%s_hold_at_done", tag), 32'(cpu_hold), 32'd1);
        @(negedge clk);
        chk($sformatf("%s_done_one_cycle", tag), 32'(done), 32'd0);
        chk($sformatf("%s_hold_released", tag), 32'(cpu_hold), 32'd0);
        chk($sformatf("%s_err", tag), 32'(err), 32'(exp_err));
        chk($sformatf("%s_done_count", tag), 32'(done_cnt), 32'd1);
        chk($sformatf("%s_nwrites", tag), 32'(got_addr.size()), 32'(exp_nwr));
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd0);
        chk($sformatf("%s_wr_en", tag), 32'(wr_en), 32'd0);
        chk($sformatf("%s_wr_addr", tag), 32'(wr_addr), 32'd0);
        chk($sformatf("%s_wr_data", tag), wr_data, 32'd0);
        chk($sformatf("%s_cpu_hold", tag), 32'(cpu_hold), 32'd0);
        chk($sformatf("%s_done", tag), 32'(done), 32'd0);
        chk($sformatf("%s_err", tag), 32'(err), 32'd0);
    endtask

    vec_t    vt [6];
    byte_q_t s;
    word_q_t wq;

    initial begin
        vt[0] = '{8'h00, 8'h02, 2, '{32'h20080005, 32'h01095020, 32'h0, 32'h0}, 1'b0, 1'b0, 2};
        vt[1] = '{8'h00, 8'h00, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 0};
        vt[2] = '{8'h04, 8'h01, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1, 0};
        vt[3] = '{8'hF8, 8'h01, 1, '{32'h12345678, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 1};
        vt[4] = '{8'h00, 8'h01, 1, '{32'h11223344, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 1};
        vt[5] = '{8'h00, 8'h01, 1, '{32'h11223344, 32'h0, 32'h0, 32'h0}, 1'b1, CHK_EN, 1};

        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        for (int v = 0; v < 6; v++) begin
            wq.delete();
            for (int unsigned i = 0; i < vt[v].nw; i++) wq.push_back(vt[v].w[i]);
            s = build_stream(vt[v].hi, vt[v].lo, wq, vt[v].bad);
            run_load(s, 1'b0, 1'b0, vt[v].exp_err, int'(vt[v].exp_nwr), $sformatf("vec%0d", v));
        end

        wq = '{32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF};
        s = build_stream(8'h00, 8'h03, wq, 1'b0);
        run_load(s, 1'b1, 1'b1, 1'b0, 3, "toggle3");

        for (int r = 0; r < 5; r++) begin
            logic [10:0] cnt;
            logic [4:0]  junk;
            bit          bad;
            cnt  = 11'($urandom_range(1, 6));
            junk = 5'($urandom);
            bad  = 1'($urandom_range(0, 1));
            wq.delete();
            for (int i = 0; i < int'(cnt); i++) wq.push_back($urandom);
            s = build_stream({junk, cnt[10:8]}, cnt[7:0], wq, bad);
            model(s);
            run_load(s, 1'b1, 1'b1, model_err, exp_data.size(), $sformatf("rnd%0d", r));
        end

        wq.delete();
        for (int i = 0; i < 1024; i++) wq.push_back($urandom);
        s = build_stream(8'h04, 8'h00, wq, 1'b0);
        model(s);
        run_load(s, 1'b0, 1'b0, model_err, exp_data.size(), "full1024");

        // Abort mid-load: word 0 written, two bytes of word 1 accepted, then async reset.
        wq = '{32'hCAFEF00D, 32'h12345678};
        s = build_stream(8'h00, 8'h02, wq, 1'b0);
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int idx;
            int cyc;
            logic rdy;
            idx = 0;
            cyc = 0;
            while (idx < 8 && cyc < 100) begin
                in_valid = 1'b1;
                in_data  = s[idx];
                rdy = in_ready;
                @(posedge clk);
                if (rdy) idx++;
                @(negedge clk);
                cyc++;
            end
            chk("abort_bytes_taken", 32'(idx), 32'd8);
        end
        in_valid = 1'b0;
        chk("abort_pre_writes", 32'(got_addr.size()), 32'd1);
        chk("abort_pre_word0", got_data[0], 32'hCAFEF00D);
        chk("abort_pre_hold", 32'(cpu_hold), 32'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_more_writes", 32'(got_addr.size()), 32'd1);
        chk("abort_idle_hold", 32'(cpu_hold), 32'd0);

        wq = '{32'h8C080004};
        s = build_stream(8'h00, 8'h01, wq, 1'b0);
        run_load(s, 1'b0, 1'b0, 1'b0, 1, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
